// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit serializer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_EVEN = 2'd1;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

  localparam int MAX_DATA_W = 9;

  // Narrower words are zero-extended by the caller; zeros do not change the XOR.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                      input logic [1:0]            mode);
    case (mode)
      PARITY_EVEN: return ^data;
      PARITY_ODD:  return ~^data;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Valid/ready word handshake between the TX byte source and the serializer.
interface uart_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_hold.sv
// One-entry holding register; in_ready is the registered "empty" flag.
module uart_tx_hold #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_if.slave          in_if,
  input  logic              pop,
  output logic              full,
  output logic [DATA_W-1:0] data
);

  logic accept;

  // pop is only raised while full and accept only while empty, so they never collide.
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign in_if.in_ready = ~full;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
    end else if (pop) begin
      full <= 1'b0;
    end else if (accept) begin
      full <= 1'b1;
    end
  end

  // NOTE: the data register is not reset; it is never consumed unless full is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      data <= in_if.in_data;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit PISO: start + DATA_W bits LSB first + optional parity + 1/2 stop bits.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     baud_tick,
  uart_tx_if.slave in_if,
  output logic     tx,
  output logic     busy,
  output logic     frame_done
);

  if (DATA_W < 5 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
    $error("uart_tx_serializer: DATA_W must be 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_tx_serializer: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  localparam int               CNT_W     = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [1:0]       MODE      = 2'(PARITY_MODE);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              load, pop, hold_full;
  logic [DATA_W-1:0] hold_data;

  uart_tx_hold #(.DATA_W(DATA_W)) u_hold (
    .clk  (clk),
    .rst  (rst),
    .in_if(in_if),
    .pop  (pop),
    .full (hold_full),
    .data (hold_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    load       = 1'b0;
    pop        = 1'b0;

    if (baud_tick) begin
      unique case (state_q)
        IDLE: begin
          tx_d = 1'b1;
          load = hold_full;
        end
        START: begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = CNT_W'(1);
          state_d   = DATA;
        end
        DATA: begin
          if (bit_cnt_q != LAST_BIT) begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (MODE != PARITY_NONE) begin
            tx_d    = parity_q;
            state_d = PARITY;
          end else begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = STOP;
          end
        end
        PARITY: begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
        STOP: begin
          if (stop_cnt_q == LAST_STOP) begin
            done_d = 1'b1;
            if (hold_full) begin
              load = 1'b1;
            end else begin
              tx_d    = 1'b1;
              state_d = IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: begin
          tx_d    = 1'b1;
          state_d = IDLE;
        end
      endcase
    end

    // Shared by IDLE and the back-to-back path out of STOP.
    if (load) begin
      pop       = 1'b1;
      shift_d   = hold_data;
      parity_d  = parity_bit(MAX_DATA_W'(hold_data), MODE);
      bit_cnt_d = '0;
      tx_d      = 1'b0;
      state_d   = START;
    end
  end

  assign tx         = tx_q;
  assign frame_done = done_q;
  assign busy       = (state_q != IDLE) || hold_full;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: four serializer configurations against a per-tick frame model.
module tb_uart_tx_serializer;

  logic clk = 1'b0;
  logic rst;
  logic baud_tick;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [8:0] din [4];
  logic       val [4];
  logic       rdy [4];
  logic       txs [4];
  logic       bsy [4];
  logic       dn  [4];

  // Configurations: 8N1, 8E1, 8O1, 7N2.
  int dw_c [4] = '{8, 8, 8, 7};
  int pm_c [4] = '{0, 1, 2, 0};
  int sb_c [4] = '{1, 1, 1, 2};

  uart_tx_if #(.DATA_W(8)) if0 ();
  uart_tx_if #(.DATA_W(8)) if1 ();
  uart_tx_if #(.DATA_W(8)) if2 ();
  uart_tx_if #(.DATA_W(7)) if3 ();

  assign if0.in_valid = val[0];  assign if0.in_data = din[0][7:0];  assign rdy[0] = if0.in_ready;
  assign if1.in_valid = val[1];  assign if1.in_data = din[1][7:0];  assign rdy[1] = if1.in_ready;
  assign if2.in_valid = val[2];  assign if2.in_data = din[2][7:0];  assign rdy[2] = if2.in_ready;
  assign if3.in_valid = val[3];  assign if3.in_data = din[3][6:0];  assign rdy[3] = if3.in_ready;

  uart_tx_serializer #(.DATA_W(8), .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_if(if0.slave),
    .tx(txs[0]), .busy(bsy[0]), .frame_done(dn[0]));
  uart_tx_serializer #(.DATA_W(8), .PARITY_MODE(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_if(if1.slave),
    .tx(txs[1]), .busy(bsy[1]), .frame_done(dn[1]));
  uart_tx_serializer #(.DATA_W(8), .PARITY_MODE(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_if(if2.slave),
    .tx(txs[2]), .busy(bsy[2]), .frame_done(dn[2]));
  uart_tx_serializer #(.DATA_W(7), .PARITY_MODE(0), .STOP_BITS(2)) dut3 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_if(if3.slave),
    .tx(txs[3]), .busy(bsy[3]), .frame_done(dn[3]));

  // Expected line level and frame_done after each successive baud tick.
  bit exp_tx [$];
  bit exp_dn [$];
  bit end_pending;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic tick);
    baud_tick = tick;
    @(posedge clk);
    #1;
    baud_tick = 1'b0;
  endtask

  task automatic bit_period();
    repeat (3) cycle(1'b0);
    cycle(1'b1);
  endtask

  // A finished frame's frame_done lands on the tick that starts whatever follows it.
  function automatic void push_tick(input bit level);
    exp_tx.push_back(level);
    exp_dn.push_back(end_pending);
    end_pending = 1'b0;
  endfunction

  function automatic void add_frame(input int k, input int w);
    int ones;
    ones = 0;
    push_tick(1'b0);
    for (int i = 0; i < dw_c[k]; i++) begin
      push_tick(bit'((w >> i) & 1));
      ones += (w >> i) & 1;
    end
    if (pm_c[k] == 1) push_tick(bit'(ones % 2));
    if (pm_c[k] == 2) push_tick(bit'(1 - ones % 2));
    for (int i = 0; i < sb_c[k]; i++) push_tick(1'b1);
    end_pending = 1'b1;
  endfunction

  function automatic void add_idle(input int n);
    for (int i = 0; i < n; i++) push_tick(1'b1);
  endfunction

  task automatic play(input int k, input int n, input string tag);
    bit t_e, d_e;
    for (int i = 0; i < n; i++) begin
      if (exp_tx.size() == 0) break;
      t_e = exp_tx.pop_front();
      d_e = exp_dn.pop_front();
      bit_period();
      check($sformatf("%s tx tick%0d", tag, i), txs[k], t_e);
      check($sformatf("%s frame_done tick%0d", tag, i), dn[k], d_e);
      if (d_e) begin
        cycle(1'b0);
        check($sformatf("%s frame_done pulse width", tag), dn[k], 1'b0);
      end
    end
  endtask

  task automatic send(input int k, input int w, input string tag);
    bit ok;
    ok = 1'b0;
    din[k] = 9'(w);
    val[k] = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (rdy[k] === 1'b1) ok = 1'b1;
      cycle(1'b0);
    end
    val[k] = 1'b0;
    check($sformatf("%s accepted", tag), ok, 1'b1);
    check($sformatf("%s in_ready low after accept", tag), rdy[k], 1'b0);
  endtask

  function automatic void clear_model();
    exp_tx.delete();
    exp_dn.delete();
    end_pending = 1'b0;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w2;
    bit lit [10];

    baud_tick = 1'b0;
    rst       = 1'b1;
    for (int k = 0; k < 4; k++) begin
      val[k] = 1'b0;
      din[k] = '0;
    end
    clear_model();
    cycle(1'b1);
    cycle(1'b0);

    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset tx dut%0d", k), txs[k], 1'b1);
      check($sformatf("reset in_ready dut%0d", k), rdy[k], 1'b1);
      check($sformatf("reset busy dut%0d", k), bsy[k], 1'b0);
      check($sformatf("reset frame_done dut%0d", k), dn[k], 1'b0);
    end
    rst = 1'b0;

    // Idle ticks with an empty hold keep the line high.
    add_idle(2);
    play(0, 2, "idle");

    // 8N1 0xA5 against the literal bit sequence; capture happens without a tick.
    send(0, 'hA5, "8N1 A5");
    check("capture no tick tx", txs[0], 1'b1);
    check("capture no tick busy", bsy[0], 1'b1);
    repeat (5) cycle(1'b0);
    check("held word tx idle", txs[0], 1'b1);
    lit = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    foreach (lit[i]) push_tick(lit[i]);
    end_pending = 1'b1;
    add_idle(2);
    play(0, 12, "8N1 A5");
    check("8N1 busy after", bsy[0], 1'b0);

    // Parity variants.
    send(1, 'hA5, "8E1 A5");
    add_frame(1, 'hA5);
    add_idle(1);
    play(1, 12, "8E1 A5");
    send(2, 'hA5, "8O1 A5");
    add_frame(2, 'hA5);
    add_idle(1);
    play(2, 12, "8O1 A5");
    send(1, 'h07, "8E1 07");
    add_frame(1, 'h07);
    add_idle(1);
    play(1, 12, "8E1 07");

    // 7N2 0x55.
    send(3, 'h55, "7N2 55");
    add_frame(3, 'h55);
    add_idle(1);
    play(3, 11, "7N2 55");
    check("7N2 busy after", bsy[3], 1'b0);

    // Back-to-back frames; a valid pulse while full must not transfer.
    send(0, 'h00, "b2b first");
    add_frame(0, 'h00);
    add_frame(0, 'hFF);
    add_idle(1);
    play(0, 2, "b2b f1a");
    send(0, 'hFF, "b2b second");
    din[0] = 9'h3C;
    val[0] = 1'b1;
    cycle(1'b0);
    cycle(1'b0);
    val[0] = 1'b0;
    check("b2b ready low while full", rdy[0], 1'b0);
    play(0, 8, "b2b f1b");
    check("b2b ready low before load", rdy[0], 1'b0);
    play(0, 1, "b2b load");
    check("b2b ready high after load", rdy[0], 1'b1);
    play(0, exp_tx.size(), "b2b f2");
    check("b2b busy after", bsy[0], 1'b0);

    // Reset mid-frame with the hold full; baud_tick coincides with reset.
    send(0, 'h5A, "rst first");
    add_frame(0, 'h5A);
    play(0, 3, "rst pre");
    send(0, 'h33, "rst second");
    repeat (2) cycle(1'b0);
    rst = 1'b1;
    cycle(1'b1);
    check("rst tx", txs[0], 1'b1);
    check("rst in_ready", rdy[0], 1'b1);
    check("rst busy", bsy[0], 1'b0);
    check("rst frame_done", dn[0], 1'b0);
    rst = 1'b0;
    clear_model();
    add_idle(20);
    play(0, 20, "post rst idle");

    // Randomized word pairs, second word queued during the first frame.
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 2; r++) begin
        w  = int'($urandom_range(0, (1 << dw_c[k]) - 1));
        w2 = int'($urandom_range(0, (1 << dw_c[k]) - 1));
        send(k, w, "rand first");
        add_frame(k, w);
        add_frame(k, w2);
        add_idle(1);
        play(k, 1, "rand f1 start");
        send(k, w2, "rand second");
        play(k, exp_tx.size(), $sformatf("rand dut%0d w%0h w%0h", k, w, w2));
        check($sformatf("rand busy after dut%0d", k), bsy[k], 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
